// File: rtl/fepow_seq.sv
// fepow_seq: drives one external femul to compute x^EXPONENT mod p with left-to-right square-and-multiply.
// Optional macro FEPOW_OPCOUNT_EN adds op_count, the number of femul ops issued in the current run.
module fepow_seq #(
  parameter int unsigned         WIDTH    = 255,
  parameter int unsigned         EXP_BITS = 255,
  parameter logic [EXP_BITS-1:0] EXPONENT =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffeb
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_out
`ifdef FEPOW_OPCOUNT_EN
  ,
  output logic [9:0]       op_count
`endif
);

  localparam int unsigned     IdxW     = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [IdxW-1:0] IdxStart = IdxW'((EXP_BITS > 1) ? (EXP_BITS - 2) : 0);

  typedef enum logic [2:0] {
    StIdle,
    StSqr,
    StMul,
    StGap,
    StSqw,
    StMlw,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  xr_q, xr_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              gap_mul_q, gap_mul_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              mul_start_q, mul_start_d;
  logic [WIDTH-1:0]  mul_a_q, mul_a_d;
  logic [WIDTH-1:0]  mul_b_q, mul_b_d;
  logic              accept;

  // A start landing on the done cycle is dropped so the caller sees a clean handshake.
  assign accept = (state_q == StIdle) && start && !done_q;

  always_comb begin
    state_d     = state_q;
    xr_d        = xr_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    gap_mul_d   = gap_mul_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_d       = out_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          xr_d    = x;
          acc_d   = x;
          idx_d   = IdxStart;
          busy_d  = 1'b1;
          state_d = (EXP_BITS == 1) ? StFin : StSqr;
        end
      end
      StSqr: begin
        mul_start_d = 1'b1;
        mul_a_d     = acc_q;
        mul_b_d     = acc_q;
        gap_mul_d   = 1'b0;
        state_d     = StGap;
      end
      StMul: begin
        mul_start_d = 1'b1;
        mul_a_d     = acc_q;
        mul_b_d     = xr_q;
        gap_mul_d   = 1'b1;
        state_d     = StGap;
      end
      // mul_done may still be high from the previous op while femul latches the new one.
      StGap: begin
        state_d = gap_mul_q ? StMlw : StSqw;
      end
      StSqw: begin
        if (mul_done) begin
          acc_d = mul_out;
          if (EXPONENT[idx_q]) begin
            state_d = StMul;
          end else if (idx_q == '0) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q - IdxW'(1);
            state_d = StSqr;
          end
        end
      end
      StMlw: begin
        if (mul_done) begin
          acc_d = mul_out;
          if (idx_q == '0) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q - IdxW'(1);
            state_d = StSqr;
          end
        end
      end
      StFin: begin
        out_d   = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      xr_q        <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      gap_mul_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_q       <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      xr_q        <= xr_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      gap_mul_q   <= gap_mul_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_q       <= out_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

`ifdef FEPOW_OPCOUNT_EN
  logic [9:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (accept) begin
      op_count_d = '0;
    end else if (mul_start_d) begin
      op_count_d = op_count_q + 10'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_fepow_seq.sv
// Bench for fepow_seq: two instances (default p-2 exponent and EXPONENT=5) each backed by a
// behavioural femul with random latency; results are checked against a right-to-left modexp model.
module tb_fepow_seq;

  localparam logic [254:0] P    =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [254:0] PM2  =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffeb;
  localparam logic [254:0] HALF =
    255'h3fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffff7;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [254:0] x = '0;
  logic         s_start = 1'b0;
  logic [254:0] s_x = '0;

  logic         b_busy, b_done, b_mul_start, b_mul_done;
  logic [254:0] b_out, b_mul_a, b_mul_b, b_mul_out;
  logic         s_busy, s_done, s_mul_start, s_mul_done;
  logic [254:0] s_out, s_mul_a, s_mul_b, s_mul_out;
`ifdef FEPOW_OPCOUNT_EN
  logic [9:0]   b_op_count, s_op_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #1 clock = ~clock;

  fepow_seq u_big (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .x         (x),
    .busy      (b_busy),
    .done      (b_done),
    .out       (b_out),
    .mul_start (b_mul_start),
    .mul_a     (b_mul_a),
    .mul_b     (b_mul_b),
    .mul_done  (b_mul_done),
    .mul_out   (b_mul_out)
`ifdef FEPOW_OPCOUNT_EN
    ,
    .op_count  (b_op_count)
`endif
  );

  fepow_seq #(
    .WIDTH    (255),
    .EXP_BITS (3),
    .EXPONENT (3'b101)
  ) u_small (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (s_start),
    .x         (s_x),
    .busy      (s_busy),
    .done      (s_done),
    .out       (s_out),
    .mul_start (s_mul_start),
    .mul_a     (s_mul_a),
    .mul_b     (s_mul_b),
    .mul_done  (s_mul_done),
    .mul_out   (s_mul_out)
`ifdef FEPOW_OPCOUNT_EN
    ,
    .op_count  (s_op_count)
`endif
  );

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] t;
    t = {257'd0, a} * {257'd0, b};
    t = t % {257'd0, P};
    return t[254:0];
  endfunction

  function automatic logic [254:0] powmod(input logic [254:0] base, input logic [254:0] e,
                                          input int nbits);
    logic [254:0] r, sq;
    r  = 255'd1;
    sq = base;
    for (int i = 0; i < nbits; i++) begin
      if (e[i]) r = mulmod(r, sq);
      sq = mulmod(sq, sq);
    end
    return r;
  endfunction

  function automatic logic [254:0] rand255();
    logic [255:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return v[254:0];
  endfunction

  // Behavioural femul: mul_done is a level that stays high until the next mul_start.
  logic         bf_done = 1'b0, bf_run = 1'b0, force_done = 1'b0;
  logic [254:0] bf_a = '0, bf_b = '0, bf_p = '0, garbage = '0;
  int           bf_cnt = 0;
  always @(posedge clock) begin
    if (b_mul_start) begin
      bf_a <= b_mul_a; bf_b <= b_mul_b; bf_done <= 1'b0; bf_run <= 1'b1;
      bf_cnt <= int'($urandom_range(1, 4));
    end else if (bf_run) begin
      if (bf_cnt <= 1) begin
        bf_done <= 1'b1; bf_p <= mulmod(bf_a, bf_b); bf_run <= 1'b0;
      end else begin
        bf_cnt <= bf_cnt - 1;
      end
    end
  end
  assign b_mul_done = bf_done | force_done;
  assign b_mul_out  = force_done ? garbage : bf_p;

  logic         sf_done = 1'b0, sf_run = 1'b0;
  logic [254:0] sf_a = '0, sf_b = '0, sf_p = '0;
  int           sf_cnt = 0;
  always @(posedge clock) begin
    if (s_mul_start) begin
      sf_a <= s_mul_a; sf_b <= s_mul_b; sf_done <= 1'b0; sf_run <= 1'b1;
      sf_cnt <= int'($urandom_range(1, 4));
    end else if (sf_run) begin
      if (sf_cnt <= 1) begin
        sf_done <= 1'b1; sf_p <= mulmod(sf_a, sf_b); sf_run <= 1'b0;
      end else begin
        sf_cnt <= sf_cnt - 1;
      end
    end
  end
  assign s_mul_done = sf_done;
  assign s_mul_out  = sf_p;

  logic [254:0] r_out;
  int           r_starts, r_dones;
  bit           r_to, r_busy1;
  logic [9:0]   r_cnt;

  // Drives one run on the default instance; results are left in r_* for the caller to check.
  task automatic run_big(input logic [254:0] xin, input bit force_gap);
    r_starts = 0; r_dones = 0; r_to = 1'b1; r_out = '0; r_cnt = '0;
    @(negedge clock); x = xin; start = 1'b1;
    @(negedge clock); start = 1'b0; r_busy1 = b_busy;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      garbage    = rand255();
      force_done = force_gap && b_mul_start;
      if (b_mul_start) r_starts++;
      if (b_done) begin
        r_dones++; r_out = b_out; r_to = 1'b0;
`ifdef FEPOW_OPCOUNT_EN
        r_cnt = b_op_count;
`endif
        break;
      end
    end
    force_done = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (b_done) r_dones++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", b_busy); end
    n_checks++; if (b_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", b_done); end
    n_checks++; if (b_out !== '0) begin n_fail++; $display("FAIL reset_out got %h want 0", b_out); end
    n_checks++; if (b_mul_start !== 1'b0) begin n_fail++; $display("FAIL reset_mul_start got %0b want 0", b_mul_start); end
    n_checks++; if (b_mul_a !== '0 || b_mul_b !== '0) begin n_fail++; $display("FAIL reset_mul_ab got %h/%h want 0", b_mul_a, b_mul_b); end
    n_checks++; if (s_busy !== 1'b0 || s_out !== '0) begin n_fail++; $display("FAIL reset_small got busy %0b out %h want 0", s_busy, s_out); end
`ifdef FEPOW_OPCOUNT_EN
    n_checks++; if (b_op_count !== 10'd0) begin n_fail++; $display("FAIL reset_op_count got %0d want 0", b_op_count); end
`endif
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_inverse_two();
    run_big(255'd2, 1'b0);
    n_checks++; if (r_to) begin n_fail++; $display("FAIL inv2_timeout got no done want done"); end
    n_checks++; if (r_out !== HALF) begin n_fail++; $display("FAIL inv2_out got %h want %h", r_out, HALF); end
    n_checks++; if (r_starts != 506) begin n_fail++; $display("FAIL inv2_ops got %0d want 506", r_starts); end
    n_checks++; if (r_dones != 1) begin n_fail++; $display("FAIL inv2_done_pulses got %0d want 1", r_dones); end
    n_checks++; if (r_busy1 !== 1'b1) begin n_fail++; $display("FAIL inv2_busy got %0b want 1", r_busy1); end
`ifdef FEPOW_OPCOUNT_EN
    n_checks++; if (r_cnt !== 10'd506) begin n_fail++; $display("FAIL inv2_op_count got %0d want 506", r_cnt); end
    n_checks++; if (b_op_count !== 10'd506) begin n_fail++; $display("FAIL op_count_hold got %0d want 506", b_op_count); end
`endif
  endtask

  task automatic test_one_zero();
    run_big(255'd1, 1'b0);
    n_checks++; if (r_to || r_out !== 255'd1) begin n_fail++; $display("FAIL one_out got %h want 1", r_out); end
    n_checks++; if (r_dones != 1) begin n_fail++; $display("FAIL one_done_pulses got %0d want 1", r_dones); end
    run_big(255'd0, 1'b0);
    n_checks++; if (r_to || r_out !== 255'd0) begin n_fail++; $display("FAIL zero_out got %h want 0", r_out); end
    n_checks++; if (r_dones != 1) begin n_fail++; $display("FAIL zero_done_pulses got %0d want 1", r_dones); end
  endtask

  task automatic test_random();
    logic [254:0] xv, ev;
    for (int k = 0; k < 2; k++) begin
      xv = rand255();
      ev = powmod(xv, PM2, 255);
      run_big(xv, 1'b0);
      n_checks++; if (r_to || r_out !== ev) begin n_fail++; $display("FAIL rand_out[%0d] x %h got %h want %h", k, xv, r_out, ev); end
    end
  endtask

  task automatic test_small();
    logic [254:0] xs[2];
    logic [254:0] ea[3], eb[3], ga[4], gb[4], cur_a, cur_b, res, ev;
    int n_ops, unstable;
    bit got;
    xs[0] = 255'd2; xs[1] = rand255();
    for (int k = 0; k < 2; k++) begin
      n_ops = 0; unstable = 0; got = 1'b0; res = '0; cur_a = '0; cur_b = '0;
      @(negedge clock); s_x = xs[k]; s_start = 1'b1;
      @(negedge clock); s_start = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clock);
        if (s_mul_start) begin
          if (n_ops < 4) begin ga[n_ops] = s_mul_a; gb[n_ops] = s_mul_b; end
          n_ops++; cur_a = s_mul_a; cur_b = s_mul_b;
        end else if (n_ops > 0 && !s_mul_done && (s_mul_a !== cur_a || s_mul_b !== cur_b)) begin
          unstable++;
        end
        if (s_done) begin got = 1'b1; res = s_out; break; end
      end
      ev = powmod(xs[k], 255'd5, 3);
      n_checks++; if (!got || res !== ev) begin n_fail++; $display("FAIL small_out[%0d] got %h want %h", k, res, ev); end
      n_checks++; if (n_ops != 3) begin n_fail++; $display("FAIL small_ops[%0d] got %0d want 3", k, n_ops); end
      n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL small_operand_stable[%0d] got %0d changes want 0", k, unstable); end
      if (k == 0) begin
        ea[0] = 255'd2; eb[0] = 255'd2; ea[1] = 255'd4; eb[1] = 255'd4; ea[2] = 255'd16; eb[2] = 255'd2;
        for (int j = 0; j < 3; j++) begin
          n_checks++;
          if (j >= n_ops || ga[j] !== ea[j] || gb[j] !== eb[j]) begin
            n_fail++; $display("FAIL small_op_order[%0d] got %h*%h want %h*%h", j, ga[j], gb[j], ea[j], eb[j]);
          end
        end
        n_checks++; if (res !== 255'd32) begin n_fail++; $display("FAIL small_32 got %h want 32", res); end
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [254:0] xa, xb, ev;
    int starts, extra_ops;
    bit seen, busy_seen;
    xa = rand255(); xb = rand255(); ev = powmod(xa, PM2, 255);
    starts = 0; extra_ops = 0; seen = 1'b0; busy_seen = 1'b0;
    @(negedge clock); x = xa; start = 1'b1;
    @(negedge clock); start = 1'b0; x = xb;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      start = (i == 50 || i == 52);
      if (b_mul_start) starts++;
      if (b_done) begin seen = 1'b1; start = 1'b1; break; end
    end
    @(negedge clock); start = 1'b0;
    repeat (4) begin
      if (b_busy) busy_seen = 1'b1;
      if (b_mul_start) extra_ops++;
      @(negedge clock);
    end
    n_checks++; if (!seen || b_out !== ev) begin n_fail++; $display("FAIL ignored_start_out got %h want %h", b_out, ev); end
    n_checks++; if (starts != 506) begin n_fail++; $display("FAIL ignored_start_ops got %0d want 506", starts); end
    n_checks++; if (busy_seen || extra_ops != 0) begin n_fail++; $display("FAIL done_cycle_start got busy %0b ops %0d want 0 0", busy_seen, extra_ops); end
  endtask

  task automatic test_gap_force();
    logic [254:0] xv, ev;
    xv = rand255(); ev = powmod(xv, PM2, 255);
    run_big(xv, 1'b1);
    n_checks++; if (r_to || r_out !== ev) begin n_fail++; $display("FAIL gap_force_out got %h want %h", r_out, ev); end
    n_checks++; if (r_starts != 506) begin n_fail++; $display("FAIL gap_force_ops got %0d want 506", r_starts); end
  endtask

  task automatic test_reset_mid();
    logic [254:0] xa;
    bit found;
    xa = rand255(); found = 1'b0;
    @(negedge clock); x = xa; start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (b_mul_start && b_mul_b === xa && b_mul_a !== xa) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL reset_mid_find got no multiply want multiply"); end
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    n_checks++;
    if (b_busy !== 1'b0 || b_done !== 1'b0 || b_out !== '0 || b_mul_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_state got busy %0b done %0b out %h want 0 0 0", b_busy, b_done, b_out);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    run_big(255'd2, 1'b0);
    n_checks++; if (r_to || r_out !== HALF) begin n_fail++; $display("FAIL reset_mid_rerun got %h want %h", r_out, HALF); end
  endtask

  initial begin
    test_reset();
    test_inverse_two();
    test_one_zero();
    test_random();
    test_small();
    test_ignored_start();
    test_gap_force();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
